// File: rtl/filter_weight_sequencer.sv
// Per-filter weight fetch controller: reads one filter's taps and bias from the ROM,
// offers them to the conv engine, and holds them while every window of that filter is processed.
module filter_weight_sequencer #(
   parameter int NUM_FILTERS        = 4,
   parameter int WORDS_PER_FILTER   = 10,
   parameter int ADDR_WIDTH         = 6,
   parameter int DATA_WIDTH         = 16,
   parameter int WINDOWS_PER_FILTER = 676,
   parameter int WIN_WIDTH          = 10,
   parameter int FIDX_WIDTH         = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    mem_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [9*DATA_WIDTH-1:0] mem_taps,
   input  logic [DATA_WIDTH-1:0]   mem_bias,
   output logic [9*DATA_WIDTH-1:0] w_taps,
   output logic [DATA_WIDTH-1:0]   w_bias,
   output logic                    w_valid,
   input  logic                    w_ready,
   input  logic                    win_done,
   output logic [FIDX_WIDTH-1:0]   filter_idx,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      OFFER,
      RUN,
      FINISH
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(WORDS_PER_FILTER);
   localparam logic [WIN_WIDTH-1:0]  LAST_WIN    = WIN_WIDTH'(WINDOWS_PER_FILTER - 1);
   localparam logic [FIDX_WIDTH-1:0] LAST_FILTER = FIDX_WIDTH'(NUM_FILTERS - 1);

   state_t                    state_q;
   logic                      memEn_q;
   logic [ADDR_WIDTH-1:0]     memAddr_q;
   logic [ADDR_WIDTH-1:0]     nextAddr_d;
   logic [9*DATA_WIDTH-1:0]   wTaps_q;
   logic [DATA_WIDTH-1:0]     wBias_q;
   logic                      wValid_q;
   logic [FIDX_WIDTH-1:0]     filterIdx_q;
   logic                      done_q;
   logic [WIN_WIDTH-1:0]      winCnt_q;

   // Filters sit back to back, so the next base address is the current one plus one stride.
   always_comb begin
      nextAddr_d = memAddr_q + STRIDE;
   end

   // Single-process FSM; every output is a register loaded on the edge that enters its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         memEn_q     <= 1'b0;
         memAddr_q   <= '0;
         wTaps_q     <= '0;
         wBias_q     <= '0;
         wValid_q    <= 1'b0;
         filterIdx_q <= '0;
         done_q      <= 1'b0;
         winCnt_q    <= '0;
      end else begin
         memEn_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q     <= FETCH;
                  memEn_q     <= 1'b1;
                  memAddr_q   <= '0;
                  filterIdx_q <= '0;
               end
            end
            FETCH: begin
               state_q <= CAPTURE;
            end
            CAPTURE: begin
               wTaps_q  <= mem_taps;
               wBias_q  <= mem_bias;
               wValid_q <= 1'b1;
               state_q  <= OFFER;
            end
            OFFER: begin
               // win_done is deliberately not looked at here, even on the handshake cycle.
               if (w_ready) begin
                  wValid_q <= 1'b0;
                  winCnt_q <= '0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (win_done) begin
                  if (winCnt_q == LAST_WIN) begin
                     if (filterIdx_q < LAST_FILTER) begin
                        filterIdx_q <= filterIdx_q + 1'b1;
                        memAddr_q   <= nextAddr_d;
                        memEn_q     <= 1'b1;
                        state_q     <= FETCH;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                     end
                  end else begin
                     winCnt_q <= winCnt_q + 1'b1;
                  end
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_en     = memEn_q;
   assign mem_addr   = memAddr_q;
   assign w_taps     = wTaps_q;
   assign w_bias     = wBias_q;
   assign w_valid    = wValid_q;
   assign filter_idx = filterIdx_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_filter_weight_sequencer.sv
// Directed bench for filter_weight_sequencer with a small two-filter ROM model;
// each step checks outputs 1 time unit after the rising edge.
module tb_filter_weight_sequencer;

   localparam int NF   = 2;
   localparam int WPF  = 10;
   localparam int AW   = 6;
   localparam int DW   = 16;
   localparam int WIN  = 3;
   localparam int WINW = 10;
   localparam int FW   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              mem_en;
   logic [AW-1:0]     mem_addr;
   logic [9*DW-1:0]   mem_taps;
   logic [DW-1:0]     mem_bias;
   logic [9*DW-1:0]   w_taps;
   logic [DW-1:0]     w_bias;
   logic              w_valid;
   logic              w_ready;
   logic              win_done;
   logic [FW-1:0]     filter_idx;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int doneCount = 0;
   int hsCount = 0;
   int memEnCount = 0;

   filter_weight_sequencer #(
      .NUM_FILTERS(NF), .WORDS_PER_FILTER(WPF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .WINDOWS_PER_FILTER(WIN), .WIN_WIDTH(WINW), .FIDX_WIDTH(FW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_taps(mem_taps), .mem_bias(mem_bias), .w_taps(w_taps), .w_bias(w_bias),
      .w_valid(w_valid), .w_ready(w_ready), .win_done(win_done),
      .filter_idx(filter_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ROM: word at base+k is base+k+1, bias is base+10; junk whenever no read is issued.
   always @(posedge clk) begin
      if (mem_en) begin
         for (int k = 0; k < 9; k++) mem_taps[k*DW +: DW] <= DW'(mem_addr) + DW'(k + 1);
         mem_bias <= DW'(mem_addr) + DW'(10);
      end else begin
         mem_taps <= {9{16'hBEEF}};
         mem_bias <= 16'hBEEF;
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (done) doneCount <= doneCount + 1;
         if (w_valid && w_ready) hsCount <= hsCount + 1;
         if (mem_en) memEnCount <= memEnCount + 1;
      end
   end

   function automatic logic [9*DW-1:0] tapsFor(input int base);
      logic [9*DW-1:0] t;
      for (int k = 0; k < 9; k++) t[k*DW +: DW] = DW'(base + k + 1);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic wr, input logic wd);
      start    = s;
      rst      = r;
      w_ready  = wr;
      win_done = wd;
   endtask

   task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
         $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pulseWin(input logic wr);
      applyStimulus(1'b0, 1'b0, wr, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, wr, 1'b0);
      tick();
   endtask

   initial begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_addr", mem_addr, 0);
      checkOutput("rst_taps", w_taps, 0);
      checkOutput("rst_bias", w_bias, 0);
      checkOutput("rst_valid", w_valid, 0);
      checkOutput("rst_idx", filter_idx, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);

      // Basic pass with w_ready held high; start is sampled at the end of cycle 0.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("c1_mem_en", mem_en, 1);
      checkOutput("c1_addr", mem_addr, 0);
      checkOutput("c1_busy", busy, 1);
      checkOutput("c1_valid", w_valid, 0);
      tick();
      checkOutput("c2_mem_en", mem_en, 0);
      checkOutput("c2_valid", w_valid, 0);
      tick();
      checkOutput("c3_valid", w_valid, 1);
      checkOutput("f0_taps", w_taps, tapsFor(0));
      checkOutput("f0_bias", w_bias, 10);
      tick();
      checkOutput("f0_run_valid", w_valid, 0);
      checkOutput("f0_run_taps", w_taps, tapsFor(0));
      pulseWin(1'b1);
      pulseWin(1'b1);
      checkOutput("f0_idx_hold", filter_idx, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("f1_mem_en", mem_en, 1);
      checkOutput("f1_addr", mem_addr, 10);
      checkOutput("f1_idx", filter_idx, 1);
      tick();
      checkOutput("f1_cap_mem_en", mem_en, 0);
      tick();
      checkOutput("f1_valid", w_valid, 1);
      checkOutput("f1_taps", w_taps, tapsFor(10));
      checkOutput("f1_bias", w_bias, 20);
      tick();
      pulseWin(1'b1);
      pulseWin(1'b1);
      checkOutput("f1_no_done_yet", done, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("fin_done", done, 1);
      checkOutput("fin_busy", busy, 1);
      tick();
      checkOutput("idle_done", done, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_idx", filter_idx, 1);
      checkOutput("idle_taps", w_taps, tapsFor(10));
      checkOutput("pass1_done_cnt", doneCount, 1);
      checkOutput("pass1_hs_cnt", hsCount, 2);
      checkOutput("pass1_memen_cnt", memEnCount, 2);

      // Backpressure in OFFER with stray win_done pulses that must not be counted.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("bp_valid0", w_valid, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, (i % 2) == 0);
         tick();
         checkOutput("bp_valid", w_valid, 1);
         checkOutput("bp_taps", w_taps, tapsFor(0));
      end
      // Handshake and win_done together: only the handshake counts.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sim_valid", w_valid, 0);
      checkOutput("sim_hs_cnt", hsCount, 3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("busy_start_memen", mem_en, 0);
      pulseWin(1'b0);
      pulseWin(1'b0);
      checkOutput("sim_idx_hold", filter_idx, 0);
      checkOutput("sim_mem_en_hold", mem_en, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("p2_f1_mem_en", mem_en, 1);
      checkOutput("p2_f1_addr", mem_addr, 10);
      checkOutput("p2_f1_idx", filter_idx, 1);
      tick();
      tick();
      checkOutput("p2_f1_valid", w_valid, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      pulseWin(1'b1);

      // Synchronous reset in the middle of filter 1.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mrst_busy", busy, 0);
      checkOutput("mrst_idx", filter_idx, 0);
      checkOutput("mrst_taps", w_taps, 0);
      checkOutput("mrst_bias", w_bias, 0);
      checkOutput("mrst_addr", mem_addr, 0);
      checkOutput("mrst_valid", w_valid, 0);
      checkOutput("mrst_done_cnt", doneCount, 1);
      tick();
      checkOutput("mrst_idle", busy, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("p3_mem_en", mem_en, 1);
      checkOutput("p3_addr", mem_addr, 0);
      tick();
      tick();
      checkOutput("p3_taps", w_taps, tapsFor(0));
      tick();
      pulseWin(1'b1);
      pulseWin(1'b1);
      pulseWin(1'b1);
      tick();
      checkOutput("p3_f1_taps", w_taps, tapsFor(10));
      tick();
      pulseWin(1'b1);
      pulseWin(1'b1);
      pulseWin(1'b1);
      checkOutput("p3_busy", busy, 0);
      checkOutput("p3_done_cnt", doneCount, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
